// File: rtl/rr_grant_sequencer_pkg.sv
// Shared constants and state encoding for the round-robin grant sequencer.
// Combinational helpers only; no latency, no backpressure.
package rr_grant_sequencer_pkg;

    localparam int N_REQ         = 4;
    localparam int IDX_W         = 2;
    localparam int MAX_HOLD_DFLT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter only has to reach MAX_HOLD-1, so log2(MAX_HOLD) bits suffice.
    function automatic int cnt_width(input int max_hold);
        return (max_hold <= 2) ? 1 : $clog2(max_hold);
    endfunction

    localparam int CNT_W_DFLT = cnt_width(MAX_HOLD_DFLT);

endpackage

// File: rtl/rr_grant_sequencer_pick.sv
// Rotating-priority pick: first set req bit scanning from ptr upward, mod 4.
// Purely combinational, zero latency; no backpressure.
module rr_pick
    import rr_grant_sequencer_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // 2-bit addition wraps naturally, giving the mod-4 scan.
            cand = ptr + k[IDX_W-1:0];
            if (!found && req[cand]) begin
                pick_idx = cand;
                found    = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin 4-way arbiter with registered grant index/valid and hold timeout.
// Latency: 1 cycle req->grant; back-to-back handoff without a bubble.
// Backpressure: holder keeps the grant until release, dropping req, or MAX_HOLD cycles.
module rr_grant_sequencer
    import rr_grant_sequencer_pkg::*;
#(
    parameter int N_REQ_P  = N_REQ,
    parameter int MAX_HOLD = MAX_HOLD_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic               gnt_release,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam int CNT_W = cnt_width(MAX_HOLD);

    if (N_REQ_P != 4) begin : g_bad_nreq
        $error("rr_grant_sequencer: N_REQ must be 4 to match the 2-to-4 decoder");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_grant_sequencer: MAX_HOLD must be in 2..255");
    end

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic               timeout;
    logic               holder_req;
    logic               grant_end;
    logic [IDX_W-1:0]   next_ptr;
    logic [IDX_W-1:0]   arb_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;

    assign timeout    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign holder_req = req[gnt_idx];
    assign grant_end  = gnt_release || !holder_req || timeout;
    assign next_ptr   = gnt_idx + IDX_W'(1);
    // Ending a grant re-arbitrates in the same cycle from the advanced pointer.
    assign arb_ptr    = (state == GRANT) ? next_ptr : ptr;

    rr_pick u_pick (
        .req      (req),
        .ptr      (arb_ptr),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        ptr <= next_ptr;
                        // A forced revoke only when the holder still wanted it and did not release.
                        preempt <= timeout && !gnt_release && holder_req;
                        if (any_req) begin
                            gnt_idx  <= pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            gnt_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (!timeout) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
